// File: rtl/pmem_arbiter_pkg.sv
// rtl/pmem_arbiter_pkg.sv - shared types and default widths for the pmem arbiter (ARB_RR_EN selects round-robin)
package arb_types;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_XFER = 2'd1,
        D_XFER = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/pmem_arbiter_pick.sv
// rtl/pmem_arbiter_pick.sv - winner selection; ARB_RR_EN adds the last-grant register for round-robin
module arb_pick
    import arb_types::*;
(
`ifdef ARB_RR_EN
    input  logic   clk,
    input  logic   rst,
    input  logic   grant_en,
`endif
    input  logic   i_req,
    input  logic   d_req,
    output grant_t winner
);

`ifdef ARB_RR_EN
    grant_t last_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= GNT_I;
        end else if (grant_en) begin
            last_grant <= winner;
        end
    end

    // On a tie the cache that did not win last time goes first.
    always_comb begin
        winner = d_req ? GNT_D : GNT_I;
        if (i_req && d_req) begin
            winner = (last_grant == GNT_D) ? GNT_I : GNT_D;
        end
    end
`else
    assign winner = d_req ? GNT_D : GNT_I;
`endif

endmodule

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - I/D cacheline arbiter in front of the memory adaptor (ARB_RR_EN selects round-robin)
module pmem_arbiter
    import arb_types::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp
);

    arb_state_t state;
    grant_t     winner;
    logic       d_req;
    logic       grant_en;

    assign d_req    = d_read | d_write;
    assign grant_en = (state == IDLE) && (i_read || d_req);

    arb_pick u_pick (
`ifdef ARB_RR_EN
        .clk      (clk),
        .rst      (rst),
        .grant_en (grant_en),
`endif
        .i_req    (i_read),
        .d_req    (d_req),
        .winner   (winner)
    );

    // Adaptor-facing signals come only from these registers so they stay
    // frozen for the whole transfer regardless of what the caches do.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_en) begin
                        if (winner == GNT_D) begin
                            state   <= D_XFER;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_write <= d_write;
                            m_read  <= ~d_write;
                        end else begin
                            state   <= I_XFER;
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                            m_write <= 1'b0;
                            m_read  <= 1'b1;
                        end
                    end
                end
                I_XFER, D_XFER: begin
                    if (m_resp) begin
                        state   <= IDLE;
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign i_resp  = (state == I_XFER) && m_resp;
    assign d_resp  = (state == D_XFER) && m_resp;
    assign i_rdata = i_resp ? m_rdata : '0;
    assign d_rdata = d_resp ? m_rdata : '0;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - scoreboard bench for pmem_arbiter (honours ARB_RR_EN)
module tb_pmem_arbiter;

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [31:0] addr;
        logic [255:0] wdata;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read, d_read, d_write, m_resp;
    logic [31:0]  i_addr, d_addr;
    logic [255:0] d_wdata, m_rdata;
    logic [255:0] i_rdata, d_rdata, m_wdata;
    logic         i_resp, d_resp, m_read, m_write;
    logic [31:0]  m_addr;

    int   total = 0;
    int   bad   = 0;
    bit   adapt_en = 0;
    bit   mon_en   = 0;
    txn_t exp_q[$];
`ifdef ARB_RR_EN
    bit   rr_last_d = 0;
`endif

    pmem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_resp(m_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: requests raised together are served one at a time; a tie
    // goes to D, or with round-robin to whichever cache was not granted last.
    task automatic model_round(input bit ir, input bit dr, input txn_t ti, input txn_t td);
        bit d_first;
        if (ir && dr) begin
`ifdef ARB_RR_EN
            d_first = !rr_last_d;
            rr_last_d = !d_first;
`else
            d_first = 1;
`endif
            if (d_first) begin exp_q.push_back(td); exp_q.push_back(ti); end
            else         begin exp_q.push_back(ti); exp_q.push_back(td); end
        end else if (ir) begin
            exp_q.push_back(ti);
`ifdef ARB_RR_EN
            rr_last_d = 0;
`endif
        end else begin
            exp_q.push_back(td);
`ifdef ARB_RR_EN
            rr_last_d = 1;
`endif
        end
    endtask

    // Adaptor: answers every started transaction after 1..5 cycles.
    initial begin
        int lat;
        m_resp  = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (adapt_en && (m_read || m_write)) begin
                lat = $urandom_range(1, 5);
                repeat (lat) @(posedge clk);
                #1; m_resp = 1'b1; m_rdata = rand256();
                @(posedge clk); #1; m_resp = 1'b0; m_rdata = '0;
            end
        end
    end

    // Monitor: pops the expected transaction when the adaptor request rises.
    initial begin
        bit   prev_act;
        bit   act;
        txn_t cur;
        prev_act = 0;
        cur = '{0, 0, 32'h0, 256'h0};
        forever begin
            @(negedge clk);
            if (mon_en) begin
                act = m_read || m_write;
                if (act && !prev_act) begin
                    check("txn_expected", 256'(exp_q.size() != 0), 256'(1));
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        check("txn_write", 256'(m_write), 256'(cur.wr));
                        check("txn_read", 256'(m_read), 256'(!cur.wr));
                        check("txn_addr", 256'(m_addr), 256'(cur.addr));
                        if (cur.wr) check("txn_wdata", m_wdata, cur.wdata);
                    end
                end else if (act) begin
                    check("hold_addr", 256'(m_addr), 256'(cur.addr));
                    check("hold_dir", 256'({m_read, m_write}), 256'({!cur.wr, cur.wr}));
                end
                if (act && m_resp) begin
                    check("i_resp_own", 256'(i_resp), 256'(!cur.is_d));
                    check("d_resp_own", 256'(d_resp), 256'(cur.is_d));
                    check("i_rdata_own", i_rdata, cur.is_d ? 256'h0 : m_rdata);
                    check("d_rdata_own", d_rdata, cur.is_d ? m_rdata : 256'h0);
                end else begin
                    check("quiet_resp", 256'({i_resp, d_resp}), 256'h0);
                    check("quiet_rdata", i_rdata | d_rdata, 256'h0);
                end
                prev_act = act;
            end
        end
    end

    task automatic run_round();
        bit   ir, early;
        logic [1:0] dm;
        bit   need_i, need_d;
        int   n;
        txn_t ti, td;
        ir    = $urandom_range(0, 1);
        dm    = 2'($urandom_range(0, 3));
        if (!ir && dm == 2'b00) ir = 1;
        early = $urandom_range(0, 1) && !(ir && dm != 2'b00);
        ti = '{0, 0, $urandom, 256'h0};
        td = '{1, dm[1], $urandom, rand256()};
        @(posedge clk); #1;
        i_read = ir; i_addr = ti.addr;
        d_read = dm[0]; d_write = dm[1]; d_addr = td.addr; d_wdata = td.wdata;
        model_round(ir, dm != 2'b00, ti, td);
        @(posedge clk); #1;
        check("start_latency", 256'(m_read | m_write), 256'(1));
        if (early) begin
            i_read = 0; d_read = 0; d_write = 0;
        end
        need_i = ir;
        need_d = (dm != 2'b00);
        n = 0;
        while ((need_i || need_d) && n < 400) begin
            @(negedge clk);
            n++;
            if (need_i && i_resp) begin need_i = 0; i_read = 0; end
            if (need_d && d_resp) begin need_d = 0; d_read = 0; d_write = 0; end
        end
        check("resp_timeout", 256'({need_i, need_d}), 256'h0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    initial begin
        rst = 1'b0;
        i_read = 0; d_read = 0; d_write = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_rw", 256'({m_read, m_write}), 256'h0);
        check("rst_m_addr", 256'(m_addr), 256'h0);
        check("rst_m_wdata", m_wdata, 256'h0);
        check("rst_resp", 256'({i_resp, d_resp}), 256'h0);
        rst = 1'b1;

        // m_resp while idle must be ignored
        @(posedge clk); #1;
        m_resp = 1'b1; m_rdata = {32{8'hAA}};
        @(negedge clk);
        check("idle_mresp_resp", 256'({i_resp, d_resp}), 256'h0);
        check("idle_mresp_rdata", i_rdata | d_rdata, 256'h0);
        @(posedge clk); #1;
        m_resp = 1'b0; m_rdata = '0;
        check("idle_mresp_stay", 256'({m_read, m_write}), 256'h0);

        // reset in the middle of a D read, then re-arbitration of held request
        d_read = 1; d_addr = 32'h0000_1000;
        @(posedge clk); #1;
        check("d_read_start", 256'(m_read), 256'(1));
        check("d_read_addr", 256'(m_addr), 256'h1000);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("async_rst_m_read", 256'(m_read), 256'(0));
        check("async_rst_resp", 256'({i_resp, d_resp}), 256'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rearb_m_read", 256'(m_read), 256'(1));
        @(posedge clk); #1;
        m_resp = 1'b1; m_rdata = {32{8'h5C}};
        @(negedge clk);
        check("rearb_d_resp", 256'({i_resp, d_resp}), 256'b01);
        check("rearb_d_rdata", d_rdata, {32{8'h5C}});
        @(posedge clk); #1;
        m_resp = 1'b0; m_rdata = '0; d_read = 0;
        check("rearb_clear", 256'({m_read, m_write}), 256'h0);

        // fresh reset so the round-robin history starts at I
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        adapt_en = 1;
        mon_en   = 1;
        for (int r = 0; r < 60; r++) run_round();
        repeat (3) @(posedge clk);
        check("queue_drained", 256'(exp_q.size()), 256'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
